// File: rtl/week_alarm.sv
// Purpose: weekday alarm clock controller fed by the week counter's s/m/h/w outputs.
// Latency: ring and state change on the edge after the cycle in which the match is seen.
// Backpressure: none; strobes are sampled every cycle and requests that do not apply are dropped.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   s, m, h, w              current time and weekday from the week counter
//   arm                     level enable; 0 forces IDLE
//   set_en/set_h/set_m/set_mask  alarm load strobe and values
//   snooze, stop            one-cycle user requests
//   ring, state             sounding output and controller state
//   alarm_h, alarm_m        stored alarm time
//   snz_used                snoozes consumed in the current alarm event
//   set_err                 one-cycle pulse when a load is rejected
module week_alarm #(
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] s,
   input  logic [5:0] m,
   input  logic [4:0] h,
   input  logic [2:0] w,
   input  logic       arm,
   input  logic       set_en,
   input  logic [4:0] set_h,
   input  logic [5:0] set_m,
   input  logic [7:0] set_mask,
   input  logic       snooze,
   input  logic       stop,
   output logic       ring,
   output logic [1:0] state,
   output logic [4:0] alarm_h,
   output logic [5:0] alarm_m,
   output logic [1:0] snz_used,
   output logic       set_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      RINGING = 2'b10,
      SNOOZE  = 2'b11
   } state_t;

   localparam logic [7:0]  RING_LOAD = 8'(RING_SECS - 1);
   localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60 - 1);
   localparam logic [1:0]  SNZ_MAX   = 2'(MAX_SNOOZE);

   state_t      st;
   logic [7:0]  mask;
   logic [5:0]  s_q;
   logic [7:0]  ring_cnt;
   logic [11:0] snz_cnt;

   logic new_sec;
   logic match;
   logic set_ok;

   // A "second" is any change of s; a counter held in reset (s stuck at 0)
   // therefore never produces a match.
   assign new_sec = (s != s_q);
   assign match   = new_sec && (s == 6'd0) && (m == alarm_m) && (h == alarm_h) && mask[w];
   assign set_ok  = (set_h <= 5'd23) && (set_m <= 6'd59);
   assign state   = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= IDLE;
         ring     <= 1'b0;
         alarm_h  <= 5'd0;
         alarm_m  <= 6'd0;
         mask     <= 8'd0;
         snz_used <= 2'd0;
         set_err  <= 1'b0;
         ring_cnt <= 8'd0;
         snz_cnt  <= 12'd0;
         s_q      <= 6'd0;
      end else begin
         s_q     <= s;
         set_err <= 1'b0;

         // Loading is independent of state, so the alarm can be programmed while disarmed.
         if (set_en) begin
            if (set_ok) begin
               alarm_h <= set_h;
               alarm_m <= set_m;
               mask    <= set_mask;
            end else begin
               set_err <= 1'b1;
            end
         end

         if (!arm) begin
            st       <= IDLE;
            ring     <= 1'b0;
            snz_used <= 2'd0;
         end else begin
            case (st)
               IDLE: begin
                  st <= ARMED;
               end

               ARMED: begin
                  // A load in the same cycle outranks the match.
                  if (!set_en && match) begin
                     st       <= RINGING;
                     ring     <= 1'b1;
                     ring_cnt <= RING_LOAD;
                  end
               end

               RINGING: begin
                  if (set_en || stop) begin
                     st       <= ARMED;
                     ring     <= 1'b0;
                     snz_used <= 2'd0;
                  end else if (snooze && (snz_used < SNZ_MAX)) begin
                     st       <= SNOOZE;
                     ring     <= 1'b0;
                     snz_used <= snz_used + 2'd1;
                     snz_cnt  <= SNZ_LOAD;
                  end else if (new_sec) begin
                     // An exhausted snooze request falls through so the ring still times out.
                     if (ring_cnt == 8'd0) begin
                        st       <= ARMED;
                        ring     <= 1'b0;
                        snz_used <= 2'd0;
                     end else begin
                        ring_cnt <= ring_cnt - 8'd1;
                     end
                  end
               end

               SNOOZE: begin
                  if (set_en || stop) begin
                     st       <= ARMED;
                     ring     <= 1'b0;
                     snz_used <= 2'd0;
                  end else if (new_sec) begin
                     if (snz_cnt == 12'd0) begin
                        st       <= RINGING;
                        ring     <= 1'b1;
                        ring_cnt <= RING_LOAD;
                     end else begin
                        snz_cnt <= snz_cnt - 12'd1;
                     end
                  end
               end

               default: begin
                  st <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
